// File: rtl/pcie_phy_sram_loader_if.sv
// SRAM-style port bundle: address, read/write enables, write data and read data
// returned one cycle after the read enable.
interface pcie_phy_sram_loader_if #(
    parameter int WD_RAM = 16,
    parameter int PW_RAM = 15
);
    logic [PW_RAM-1:0] addr;
    logic              rd_en;
    logic              wr_en;
    logic [WD_RAM-1:0] wr_data;
    logic [WD_RAM-1:0] rd_data;

    modport master (output addr, rd_en, wr_en, wr_data, input rd_data);
    modport slave  (input addr, rd_en, wr_en, wr_data, output rd_data);
endinterface

// File: rtl/pcie_phy_sram_loader.sv
// Loads a firmware image into the PHY SRAM, verifies it by read-back checksum,
// then hands the SRAM port over to the PHY as a combinational bypass.
module pcie_phy_sram_loader #(
    parameter int WD_RAM = 16,
    parameter int PW_RAM = 15,
    parameter int DP_RAM = 20000
) (
    input  logic                   phy0_sram_clk,
    input  logic                   phy0_sram_rst,
    input  logic                   ld_start,
    input  logic [PW_RAM-1:0]      ld_num_words,
    input  logic [WD_RAM-1:0]      ld_exp_csum,
    input  logic                   ld_valid,
    input  logic [WD_RAM-1:0]      ld_data,
    output logic                   ld_ready,
    output logic                   ld_busy,
    output logic                   ld_csum_err,
    output logic [WD_RAM-1:0]      ld_csum,
    output logic                   phy_ext_ld_done,
    pcie_phy_sram_loader_if.slave  phy_sram,
    pcie_phy_sram_loader_if.master mem_sram
);
    typedef enum logic [1:0] {IDLE, LOAD, VERIFY, DONE} state_t;

    localparam logic [PW_RAM-1:0] DEPTH = PW_RAM'(DP_RAM);
    localparam logic [PW_RAM-1:0] ONE   = PW_RAM'(1);

    state_t            state, state_nxt;
    logic [PW_RAM-1:0] n_words;
    logic [PW_RAM-1:0] wptr;
    logic [PW_RAM-1:0] rptr;
    logic [PW_RAM-1:0] scnt;
    logic [WD_RAM-1:0] exp_csum;
    logic [WD_RAM-1:0] acc;
    logic [WD_RAM-1:0] acc_sum;
    logic              sample_q;

    logic [PW_RAM-1:0] addr_q;
    logic              rd_en_q;
    logic              wr_en_q;
    logic [WD_RAM-1:0] wr_data_q;

    logic start_ok;
    logic wr_hs;
    logic last_wr;
    logic last_sample;

    assign start_ok    = ld_start && (ld_num_words != '0);
    // Handshake is decoded from state, not ld_ready, to keep the FSM free of a comb loop.
    assign wr_hs       = ld_valid && (state == LOAD);
    assign last_wr     = wr_hs && (wptr == n_words - ONE);
    assign last_sample = sample_q && (scnt == n_words - ONE);
    assign acc_sum     = acc + mem_sram.rd_data;

    always_ff @(posedge phy0_sram_clk or posedge phy0_sram_rst) begin
        if (phy0_sram_rst) state <= IDLE;
        else               state <= state_nxt;
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt       = state;
        ld_ready        = 1'b0;
        ld_busy         = 1'b0;
        phy_ext_ld_done = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) state_nxt = LOAD;
            end
            LOAD: begin
                ld_ready = 1'b1;
                ld_busy  = 1'b1;
                if (last_wr) state_nxt = VERIFY;
            end
            VERIFY: begin
                ld_busy = 1'b1;
                if (last_sample) state_nxt = (acc_sum == exp_csum) ? DONE : IDLE;
            end
            DONE: begin
                phy_ext_ld_done = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge phy0_sram_clk or posedge phy0_sram_rst) begin
        if (phy0_sram_rst) begin
            n_words     <= '0;
            wptr        <= '0;
            rptr        <= '0;
            scnt        <= '0;
            exp_csum    <= '0;
            acc         <= '0;
            sample_q    <= 1'b0;
            addr_q      <= '0;
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_data_q   <= '0;
            ld_csum     <= '0;
            ld_csum_err <= 1'b0;
        end else begin
            // Memory port is idle unless this cycle issues an access.
            addr_q    <= '0;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            sample_q  <= rd_en_q;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        n_words     <= (ld_num_words > DEPTH) ? DEPTH : ld_num_words;
                        exp_csum    <= ld_exp_csum;
                        ld_csum_err <= 1'b0;
                        acc         <= '0;
                        wptr        <= '0;
                        rptr        <= '0;
                        scnt        <= '0;
                    end
                end
                LOAD: begin
                    if (wr_hs) begin
                        wr_en_q   <= 1'b1;
                        addr_q    <= wptr;
                        wr_data_q <= ld_data;
                        wptr      <= last_wr ? '0 : wptr + ONE;
                    end
                end
                VERIFY: begin
                    if (rptr != n_words) begin
                        rd_en_q <= 1'b1;
                        addr_q  <= rptr;
                        rptr    <= rptr + ONE;
                    end
                    if (sample_q) begin
                        acc  <= acc_sum;
                        scnt <= scnt + ONE;
                    end
                    if (last_sample) begin
                        ld_csum     <= acc_sum;
                        ld_csum_err <= (acc_sum != exp_csum);
                    end
                end
                default: ;
            endcase
        end
    end

    // Outside DONE the PHY side is fully isolated from the memory.
    assign mem_sram.addr     = (state == DONE) ? phy_sram.addr    : addr_q;
    assign mem_sram.rd_en    = (state == DONE) ? phy_sram.rd_en   : rd_en_q;
    assign mem_sram.wr_en    = (state == DONE) ? phy_sram.wr_en   : wr_en_q;
    assign mem_sram.wr_data  = (state == DONE) ? phy_sram.wr_data : wr_data_q;
    assign phy_sram.rd_data  = (state == DONE) ? mem_sram.rd_data : '0;
endmodule

// File: tb/tb_pcie_phy_sram_loader.sv
// Bench for pcie_phy_sram_loader: an SRAM model on the memory side, a phase-level
// expectation model, a per-cycle compare process and directed load scenarios.
module tb_pcie_phy_sram_loader;
    localparam int WD = 16;
    localparam int PW = 15;
    localparam int DP = 20000;

    logic          clk = 1'b0;
    logic          rst;
    logic          ld_start = 1'b0;
    logic [PW-1:0] ld_num_words = '0;
    logic [WD-1:0] ld_exp_csum = '0;
    logic          ld_valid = 1'b0;
    logic [WD-1:0] ld_data = '0;
    logic          ld_ready;
    logic          ld_busy;
    logic          ld_csum_err;
    logic [WD-1:0] ld_csum;
    logic          phy_ext_ld_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pcie_phy_sram_loader_if #(.WD_RAM(WD), .PW_RAM(PW)) phy_if ();
    pcie_phy_sram_loader_if #(.WD_RAM(WD), .PW_RAM(PW)) mem_if ();

    pcie_phy_sram_loader #(.WD_RAM(WD), .PW_RAM(PW), .DP_RAM(DP)) dut (
        .phy0_sram_clk   (clk),
        .phy0_sram_rst   (rst),
        .ld_start        (ld_start),
        .ld_num_words    (ld_num_words),
        .ld_exp_csum     (ld_exp_csum),
        .ld_valid        (ld_valid),
        .ld_data         (ld_data),
        .ld_ready        (ld_ready),
        .ld_busy         (ld_busy),
        .ld_csum_err     (ld_csum_err),
        .ld_csum         (ld_csum),
        .phy_ext_ld_done (phy_ext_ld_done),
        .phy_sram        (phy_if),
        .mem_sram        (mem_if)
    );

    // Single-port SRAM with one-cycle read latency.
    logic [WD-1:0] sram [DP];
    always @(posedge clk) begin
        if (mem_if.rd_en === 1'b1) mem_if.rd_data <= sram[mem_if.addr];
        if (mem_if.wr_en === 1'b1) sram[mem_if.addr] <= mem_if.wr_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- expectation model ----------------
    typedef enum {M_IDLE, M_LOAD, M_VERIFY, M_DONE} mphase_t;
    mphase_t       m_phase = M_IDLE;
    int            m_n = 0;
    int            m_vc = 0;
    logic [WD-1:0] m_exp = '0;
    logic [WD-1:0] m_csum = '0;
    bit            m_err = 1'b0;
    logic [WD-1:0] img[$];
    logic [WD-1:0] model_mem [DP];
    bit            e_wr = 1'b0;
    bit            e_rd = 1'b0;
    int            e_addr = 0;
    logic [WD-1:0] e_data = '0;
    bit            e_prd = 1'b0;
    logic [WD-1:0] e_prd_data = '0;

    function automatic logic [WD-1:0] image_sum();
        logic [WD-1:0] s = '0;
        foreach (img[i]) s += img[i];
        return s;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = M_IDLE; m_n = 0; m_vc = 0; m_exp = '0; m_csum = '0; m_err = 1'b0;
            img.delete();
            e_wr = 1'b0; e_rd = 1'b0; e_prd = 1'b0;
        end else begin
            e_wr = 1'b0; e_rd = 1'b0; e_prd = 1'b0;
            case (m_phase)
                M_IDLE: if (ld_start && ld_num_words != '0) begin
                    m_n     = (int'(ld_num_words) > DP) ? DP : int'(ld_num_words);
                    m_exp   = ld_exp_csum;
                    m_err   = 1'b0;
                    img.delete();
                    m_phase = M_LOAD;
                end
                M_LOAD: if (ld_valid) begin
                    e_wr   = 1'b1;
                    e_addr = img.size();
                    e_data = ld_data;
                    model_mem[e_addr] = ld_data;
                    img.push_back(ld_data);
                    if (img.size() == m_n) begin
                        m_phase = M_VERIFY;
                        m_vc    = 0;
                    end
                end
                M_VERIFY: begin
                    // verify cycle m_vc just ended: reads show in verify cycles 1..N
                    if (m_vc < m_n) begin
                        e_rd   = 1'b1;
                        e_addr = m_vc;
                    end
                    if (m_vc == m_n + 1) begin
                        m_csum = image_sum();
                        if (m_csum == m_exp) m_phase = M_DONE;
                        else begin m_err = 1'b1; m_phase = M_IDLE; end
                    end
                    m_vc++;
                end
                M_DONE: begin
                    if (phy_if.rd_en) begin e_prd = 1'b1; e_prd_data = model_mem[phy_if.addr]; end
                    if (phy_if.wr_en) model_mem[phy_if.addr] = phy_if.wr_data;
                end
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    int wr_cnt = 0;
    int last_wr_addr = -1;
    always @(negedge clk) begin
        check("ld_ready", ld_ready, m_phase == M_LOAD);
        check("ld_busy", ld_busy, (m_phase == M_LOAD) || (m_phase == M_VERIFY));
        check("ext_ld_done", phy_ext_ld_done, m_phase == M_DONE);
        check("csum_err", ld_csum_err, m_err);
        check("ld_csum", ld_csum, m_csum);
        if (m_phase == M_DONE) begin
            check("byp_addr", mem_if.addr, phy_if.addr);
            check("byp_rd_en", mem_if.rd_en, phy_if.rd_en);
            check("byp_wr_en", mem_if.wr_en, phy_if.wr_en);
            check("byp_wr_data", mem_if.wr_data, phy_if.wr_data);
            if (e_prd) check("byp_rd_data", phy_if.rd_data, e_prd_data);
        end else begin
            check("mem_wr_en", mem_if.wr_en, e_wr);
            check("mem_rd_en", mem_if.rd_en, e_rd);
            if (e_wr || e_rd) check("mem_addr", mem_if.addr, e_addr);
            if (e_wr) check("mem_wr_data", mem_if.wr_data, e_data);
            check("phy_rd_iso", phy_if.rd_data, 0);
            if (mem_if.wr_en === 1'b1) begin
                wr_cnt++;
                last_wr_addr = int'(mem_if.addr);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic start(input int n, input logic [WD-1:0] e);
        ld_start     = 1'b1;
        ld_num_words = PW'(n);
        ld_exp_csum  = e;
        tick();
        ld_start = 1'b0;
    endtask

    task automatic stream(input logic [WD-1:0] w[$], input int cnt, input bit rnd);
        int idx = 0;
        int budget = 0;
        bit hs;
        while (idx < cnt) begin
            ld_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            ld_data  = w[idx];
            hs = ld_valid && ld_ready;
            tick();
            if (hs) idx++;
            budget++;
            if (budget > 4 * cnt + 20) begin
                check("stream_timeout", idx, cnt);
                break;
            end
        end
        ld_valid = 1'b0;
        ld_data  = '0;
    endtask

    task automatic wait_not_busy(input int budget);
        int c = 0;
        while (ld_busy === 1'b1 && c < budget) begin
            tick();
            c++;
        end
        if (c >= budget) check("busy_timeout", ld_busy, 0);
    endtask

    task automatic phy_write_read(input logic [PW-1:0] a, input logic [WD-1:0] d);
        phy_if.wr_en = 1'b1; phy_if.addr = a; phy_if.wr_data = d;
        tick();
        phy_if.wr_en = 1'b0; phy_if.rd_en = 1'b1; phy_if.wr_data = '0;
        tick();
        phy_if.rd_en = 1'b0; phy_if.addr = '0;
    endtask

    logic [WD-1:0] img1[$] = '{16'h0001, 16'h0002, 16'h0003, 16'hFFFF};
    logic [WD-1:0] img3[$] = '{16'h0010, 16'h0020, 16'h0030, 16'h0040,
                               16'h0050, 16'h0060, 16'h0070, 16'h0080};
    logic [WD-1:0] img6[$];
    logic [WD-1:0] big[$];
    logic [WD-1:0] big_sum;
    int base;

    initial begin
        rst = 1'b0;
        phy_if.addr = '0; phy_if.rd_en = 1'b0; phy_if.wr_en = 1'b0; phy_if.wr_data = '0;
        for (int i = 0; i < 10; i++) img6.push_back(WD'(16'h0100 + i));
        #1 rst = 1'b1;
        #1;
        check("rst_busy", ld_busy, 0);
        check("rst_done", phy_ext_ld_done, 0);
        check("rst_csum", ld_csum, 0);
        check("rst_mem_wr_en", mem_if.wr_en, 0);
        tick(); tick();
        rst = 1'b0;

        // 1: basic load, checksum 1+2+3+0xFFFF wraps to 0x0005
        start(4, 16'h0005);
        stream(img1, 4, 1'b0);
        ld_valid = 1'b1; ld_data = 16'hDEAD;   // surplus word must not be taken
        tick();
        ld_valid = 1'b0;
        wait_not_busy(100);
        check("t1_csum", ld_csum, 16'h0005);
        check("t1_done", phy_ext_ld_done, 1);
        check("t1_err", ld_csum_err, 0);

        // 2 + isolation before DONE
        do_reset();
        phy_write_read(15'h0010, 16'hABCD);
        check("t5_iso_rd_data", phy_if.rd_data, 0);
        check("t5_iso_wr_en", mem_if.wr_en, 0);
        start(4, 16'h0006);
        stream(img1, 4, 1'b0);
        wait_not_busy(100);
        check("t2_csum", ld_csum, 16'h0005);
        check("t2_err", ld_csum_err, 1);
        check("t2_done", phy_ext_ld_done, 0);
        start(4, 16'h0005);
        stream(img1, 4, 1'b0);
        wait_not_busy(100);
        check("t2_retry_err", ld_csum_err, 0);
        check("t2_retry_done", phy_ext_ld_done, 1);

        // 3: random valid, then PHY bypass in DONE
        do_reset();
        base = wr_cnt;
        start(8, 16'h0240);
        stream(img3, 8, 1'b1);
        wait_not_busy(100);
        check("t3_writes", wr_cnt - base, 8);
        check("t3_last_addr", last_wr_addr, 7);
        check("t3_done", phy_ext_ld_done, 1);
        phy_write_read(15'h0010, 16'hABCD);
        check("t5_byp_rd_data", phy_if.rd_data, 16'hABCD);

        // 6: async reset mid-load, then full reload
        do_reset();
        start(10, 16'h0A2D);
        stream(img6, 3, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("t6_busy", ld_busy, 0);
        check("t6_ready", ld_ready, 0);
        check("t6_mem_wr_en", mem_if.wr_en, 0);
        check("t6_done", phy_ext_ld_done, 0);
        tick();
        rst = 1'b0;
        base = wr_cnt;
        start(10, 16'h0A2D);
        stream(img6, 10, 1'b0);
        wait_not_busy(100);
        check("t6_writes", wr_cnt - base, 10);
        check("t6_done_after", phy_ext_ld_done, 1);

        // 4: zero length ignored, oversize length clamps to the depth
        do_reset();
        start(0, 16'h0000);
        tick();
        check("t4_zero_busy", ld_busy, 0);
        big_sum = '0;
        for (int i = 0; i < DP; i++) begin
            big.push_back(WD'(i * 3 + 1));
            big_sum += WD'(i * 3 + 1);
        end
        base = wr_cnt;
        start(32'h7FFF, big_sum);
        stream(big, DP, 1'b0);
        ld_valid = 1'b1; ld_data = 16'h5555;
        tick();
        ld_valid = 1'b0;
        wait_not_busy(DP + 100);
        check("t4_writes", wr_cnt - base, DP);
        check("t4_last_addr", last_wr_addr, 19999);
        check("t4_done", phy_ext_ld_done, 1);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pcie_phy_sram_loader.md
Name: pcie_phy_sram_loader

Overview:
- Sits between the PCIe PHY's external SRAM port and the PHY memory top (single-port RAM plus ROM).
- After reset it owns the SRAM port and writes a firmware image, received as a valid/ready word stream, to consecutive addresses.
- It then reads the image back and checks a modular-sum checksum.
- On a match it asserts ext_ld_done and bypasses the PHY's SRAM port straight through to the memory.

Parameters:
- WD_RAM, 16, SRAM data width in bits.
- PW_RAM, 15, SRAM address width in bits.
- DP_RAM, 20000, SRAM depth in words; the maximum load length.

Ports:
- phy0_sram_clk  in  1  clock for the PHY SRAM domain.
- phy0_sram_rst  in  1  reset, asynchronous, active-high.
- ld_start  in  1  single-cycle pulse that starts a load; honoured only in IDLE.
- ld_num_words  in  PW_RAM  image length N; sampled when ld_start is taken.
- ld_exp_csum  in  WD_RAM  expected checksum; sampled when ld_start is taken.
- ld_valid  in  1  image word valid.
- ld_data  in  WD_RAM  image word.
- ld_ready  out  1  loader accepts a word.
- ld_busy  out  1  high in LOAD or VERIFY.
- ld_csum_err  out  1  sticky flag; last verify mismatched.
- ld_csum  out  WD_RAM  last computed checksum.
- phy_ext_ld_done  out  1  SRAM image valid; PHY may use the SRAM.
- phy_sram_addr  in  PW_RAM  PHY-side SRAM address.
- phy_sram_rd_en  in  1  PHY-side read enable.
- phy_sram_wr_en  in  1  PHY-side write enable.
- phy_sram_wr_data  in  WD_RAM  PHY-side write data.
- phy_sram_rd_data  out  WD_RAM  PHY-side read data.
- mem_sram_addr  out  PW_RAM  memory-side address.
- mem_sram_rd_en  out  1  memory-side read enable.
- mem_sram_wr_en  out  1  memory-side write enable.
- mem_sram_wr_data  out  WD_RAM  memory-side write data.
- mem_sram_rd_data  in  WD_RAM  memory read data; 1-cycle read latency.

Behaviour:
- Clocking and reset:
  - One clock, phy0_sram_clk; reset phy0_sram_rst is asynchronous, active-high.
  - Reset values: state=IDLE; every output 0; internal counters, latched N/expected checksum and accumulator all 0.
- FSM states are IDLE, LOAD, VERIFY, DONE.
- IDLE:
  - ld_ready=0.
  - On ld_start with ld_num_words!=0: latch N=min(ld_num_words, DP_RAM), latch ld_exp_csum, clear ld_csum_err and accumulator, wptr=0; next state LOAD.
  - ld_start with ld_num_words=0 is ignored.
- LOAD:
  - ld_ready=1.
  - Each cycle with ld_valid&&ld_ready: in the next cycle mem_sram_wr_en=1, mem_sram_addr=wptr, mem_sram_wr_data=ld_data (registered); wptr++.
  - Cycles without a handshake drive the mem port idle (en=0).
  - The handshake with wptr==N-1 moves to VERIFY; ld_ready falls in that same next cycle.
  - Extra words after N are not accepted.
- VERIFY:
  - Issues N registered reads, one per cycle: mem_sram_rd_en=1, addresses 0..N-1.
  - Each read's data is sampled one cycle after its rd_en cycle and accumulated: acc=(acc+mem_sram_rd_data) mod 2^WD_RAM.
  - The cycle after the last data sample: ld_csum=acc.
    - If acc==expected: next state DONE.
    - Otherwise set ld_csum_err=1 and return to IDLE, so a retry is possible.
  - Total VERIFY time is N+2 cycles.
- DONE:
  - phy_ext_ld_done=1; ld_busy=0.
  - Bypass is combinational: mem_sram_* = phy_sram_*, and phy_sram_rd_data = mem_sram_rd_data.
  - ld_start is ignored; only reset leaves DONE.
- PHY isolation outside DONE:
  - phy_sram_rd_data=0.
  - PHY rd_en/wr_en are ignored and never reach the memory.
- ld_busy=1 exactly in LOAD and VERIFY. ld_start while busy is ignored.
- Reset mid-LOAD or mid-VERIFY: immediate return to IDLE with all outputs 0. SRAM contents are undefined; a full reload is required.
- ld_csum keeps its last value until the next verify completes or reset.
- Width rules:
  - N is compared and counted on PW_RAM bits.
  - The clamp guarantees wptr never exceeds DP_RAM-1.
  - Checksum wraps silently.

Test Plan:
1. Reset, ld_start N=4, exp=0x0005, stream 0x0001,0x0002,0x0003,0xFFFF with ld_valid held high -> writes addr 0..3 on consecutive cycles, then 4 reads, ld_csum=0x0005, phy_ext_ld_done=1, ld_csum_err=0.
2. Same image with exp=0x0006 -> ld_csum=0x0005, ld_csum_err=1, back to IDLE, phy_ext_ld_done=0. Retry with exp=0x0005 -> DONE, ld_csum_err cleared.
3. ld_valid toggled randomly during LOAD with N=8 -> exactly 8 writes to addresses 0..7 with data in order, no gaps in address, mem wr_en only after handshake cycles.
4. ld_num_words=0 then ld_num_words=0x7FFF -> first ignored (stays IDLE); second clamps to 20000 and the last write address is 19999.
5. In DONE drive PHY write addr 0x10 data 0xABCD, then read addr 0x10 -> mem sees the same signals combinationally; phy_sram_rd_data=0xABCD one cycle after rd_en. Before DONE, the same PHY activity produces no mem accesses and phy_sram_rd_data=0.
6. Assert phy0_sram_rst asynchronously mid-LOAD (after 3 of 10 words) -> all outputs 0 without waiting for a clock edge, state IDLE; a new ld_start performs a full load from addr 0.
